// File: rtl/nrzi_tx_pkg.sv
// nrzi_pkg: shared FSM state type and default sizing for the NRZI transmitter.
package nrzi_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int STUFF_RUN_DEF = 6;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } nrzi_state_e;

endpackage : nrzi_pkg

// File: rtl/nrzi_tx_if.sv
// nrzi_tx_if: word handshake into the transmitter plus its serial line and
// status. The master is the word producer, the slave is nrzi_tx.
interface nrzi_tx_if
  import nrzi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              op;
  logic              busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  op,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output op,
    output busy
  );

endinterface : nrzi_tx_if

// File: rtl/nrzi_bit_enc.sv
// nrzi_bit_enc: NRZI line flop. An enabled 1 flips the line, a 0 (or no
// enable) leaves it where it is.
module nrzi_bit_enc (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic bit_val,
  output logic op
);

  // Line level: toggle on every enabled 1, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op <= 1'b0;
    end else if (en && bit_val) begin
      op <= ~op;
    end else begin
      op <= op;
    end
  end

endmodule : nrzi_bit_enc

// File: rtl/nrzi_tx.sv
// nrzi_tx: serialises DATA_W-bit words, LSB first, onto an NRZI line.
// Words are accepted through a valid/ready handshake; a new word can be
// taken on the edge that emits the last bit of the current one, so
// back-to-back words leave no gap on the line.
// Optional feature: define NRZI_TX_STUFF_EN to insert a 1 after every
// STUFF_RUN consecutive 0s on the line (the run carries across words).
module nrzi_tx
  import nrzi_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int STUFF_RUN = STUFF_RUN_DEF
) (
  input logic      clk,
  input logic      rst,
  nrzi_tx_if.slave bus
);

  localparam int              CW       = $clog2(DATA_W);
  localparam logic [CW-1:0]   LAST_IDX = CW'(DATA_W - 1);

  // Reject configurations the counters are not sized for
  if (DATA_W < 2 || STUFF_RUN < 1) begin : g_param_check
    $error("nrzi_tx: DATA_W must be >= 2 and STUFF_RUN >= 1");
  end

  nrzi_state_e       state_r;
  logic              busy_r;
  logic [DATA_W-1:0] sh_r;
  logic [CW-1:0]     cnt_r;
  logic              ready_s;
  logic              xfer_s;
  logic              enc_en_s;
  logic              enc_bit_s;
  logic              op_s;

`ifdef NRZI_TX_STUFF_EN
  localparam int            ZW      = $clog2(STUFF_RUN + 1);
  localparam logic [ZW-1:0] RUN_MAX = ZW'(STUFF_RUN);
  localparam logic [ZW-1:0] RUN_PRE = ZW'(STUFF_RUN - 1);

  logic [ZW-1:0] zrun_r;      // consecutive 0s already on the line
  logic          tail_r;      // data done, only a stuff bit still owed
  logic          stuff_due_s; // this edge emits a stuffed 1
  logic          tail_owed_s; // last data bit completes a zero run

  // Stuffing decisions for the current SHIFT edge
  always_comb begin
    stuff_due_s = 1'b0;
    tail_owed_s = 1'b0;
    if (state_r == SHIFT) begin
      stuff_due_s = (zrun_r == RUN_MAX);
      tail_owed_s = (cnt_r == LAST_IDX) && !sh_r[0] && (zrun_r == RUN_PRE);
    end else begin
      stuff_due_s = 1'b0;
      tail_owed_s = 1'b0;
    end
  end
`endif

  // Handshake ready: always in IDLE, on the last data bit in SHIFT unless a
  // stuff bit must go out first
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      IDLE:    ready_s = 1'b1;
`ifdef NRZI_TX_STUFF_EN
      SHIFT:   ready_s = !tail_r && (cnt_r == LAST_IDX) && !stuff_due_s && !tail_owed_s;
`else
      SHIFT:   ready_s = (cnt_r == LAST_IDX);
`endif
      default: ready_s = 1'b0;
    endcase
  end

  // Transfer strobe and the bit presented to the line encoder
  always_comb begin
    xfer_s   = bus.din_valid && ready_s;
    enc_en_s = (state_r == SHIFT);
`ifdef NRZI_TX_STUFF_EN
    enc_bit_s = stuff_due_s | sh_r[0];
`else
    enc_bit_s = sh_r[0];
`endif
  end

  // Word FSM: load on transfer, then one data bit (or stuffed 1) per edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      sh_r    <= '0;
      cnt_r   <= '0;
`ifdef NRZI_TX_STUFF_EN
      zrun_r  <= '0;
      tail_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            state_r <= SHIFT;
            busy_r  <= 1'b1;
            sh_r    <= bus.din;
            cnt_r   <= '0;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        SHIFT: begin
`ifdef NRZI_TX_STUFF_EN
          if (stuff_due_s) begin
            // Stuffed 1: data register and bit counter stay put
            zrun_r <= '0;
            tail_r <= 1'b0;
            if (tail_r) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              busy_r  <= 1'b1;
            end
          end else begin
            zrun_r <= sh_r[0] ? '0 : zrun_r + ZW'(1);
            if (cnt_r == LAST_IDX) begin
              if (xfer_s) begin
                sh_r  <= bus.din;
                cnt_r <= '0;
              end else if (tail_owed_s) begin
                tail_r <= 1'b1;
              end else begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
                zrun_r  <= '0;
              end
            end else begin
              sh_r  <= {1'b0, sh_r[DATA_W-1:1]};
              cnt_r <= cnt_r + CW'(1);
            end
          end
`else
          if (cnt_r == LAST_IDX) begin
            if (xfer_s) begin
              sh_r  <= bus.din;
              cnt_r <= '0;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            sh_r  <= {1'b0, sh_r[DATA_W-1:1]};
            cnt_r <= cnt_r + CW'(1);
          end
`endif
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  nrzi_bit_enc u_enc (
    .clk     (clk),
    .rst     (rst),
    .en      (enc_en_s),
    .bit_val (enc_bit_s),
    .op      (op_s)
  );

  assign bus.din_ready = ready_s;
  assign bus.op        = op_s;
  assign bus.busy      = busy_r;

endmodule : nrzi_tx

// File: tb/tb_nrzi_tx.sv
// tb_nrzi_tx: directed and randomized stimulus against a line-level model.
// The model keeps the queue of symbols still to appear on the line (data
// bits, plus stuffed 1s when NRZI_TX_STUFF_EN is defined) and derives the
// expected op, busy and din_ready from it every cycle.
module tb_nrzi_tx;

  localparam int W  = 8;
  localparam int SR = 6;
`ifdef NRZI_TX_STUFF_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  nrzi_tx_if #(.DATA_W(W)) bus ();

  nrzi_tx #(.DATA_W(W), .STUFF_RUN(SR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int           n_checks = 0;
  int           n_errors = 0;
  logic [1:0]   line_q[$];   // {is_stuff, line bit} still to be emitted
  logic [W-1:0] stim_q[$];   // words waiting to be offered
  logic         exp_op = 1'b0;
  int           run = 0;     // zeros at the end of the queued stream

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Ready when nothing is queued, or only the final data bit remains
  function automatic logic model_ready();
    return (line_q.size() == 0) || (line_q.size() == 1 && !line_q[0][1]);
  endfunction

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      line_q.push_back({1'b0, w[i]});
      if (w[i]) run = 0;
      else      run++;
      if (STUFF && run == SR) begin
        line_q.push_back(2'b11);
        run = 0;
      end
    end
  endtask

  // One clock cycle, entered and left at a negative edge
  task automatic step(input string tag);
    logic         rdy;
    logic         xfer;
    logic         idle;
    logic [W-1:0] w;
    logic [1:0]   e;
    if (stim_q.size() > 0) begin
      bus.din_valid = 1'b1;
      bus.din       = stim_q[0];
    end else begin
      bus.din_valid = 1'b0;
      bus.din       = W'($urandom);
    end
    #1;
    rdy = model_ready();
    chk({tag, ".ready"}, bus.din_ready, rdy);
    xfer = bus.din_valid && rdy;
    w    = bus.din;
    idle = (line_q.size() == 0);
    @(posedge clk);
    if (!idle) begin
      e = line_q.pop_front();
      if (e[0]) exp_op = ~exp_op;
    end
    if (xfer) begin
      if (idle) run = 0;
      push_word(w);
      w = stim_q.pop_front();
    end
    @(negedge clk);
    chk({tag, ".op"}, bus.op, exp_op);
    chk({tag, ".busy"}, bus.busy, line_q.size() != 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, ".op"}, bus.op, 1'b0);
    chk({tag, ".busy"}, bus.busy, 1'b0);
    chk({tag, ".ready"}, bus.din_ready, 1'b1);
    line_q.delete();
    stim_q.delete();
    exp_op = 1'b0;
    run    = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    @(negedge clk);
    do_reset("rst0");

    for (int i = 0; i < 5; i++) step("idle");

    stim_q.push_back(8'hA5);
    for (int i = 0; i < 10; i++) step("a5");
    chk("a5.hold", bus.op, 1'b0);

    stim_q.push_back(8'hFF);
    stim_q.push_back(8'h01);
    for (int i = 0; i < 20; i++) step("b2b");

    stim_q.push_back(8'h00);
    for (int i = 0; i < 12; i++) step("zero");

    stim_q.push_back(8'h40);
    stim_q.push_back(8'h00);
    for (int i = 0; i < 22; i++) step("carry");

    stim_q.push_back(8'h03);
    stim_q.push_back(8'h01);
    for (int i = 0; i < 22; i++) step("tail");

    stim_q.push_back(8'hF0);
    for (int i = 0; i < 3; i++) step("f0");
    do_reset("rst_mid");
    stim_q.push_back(8'h01);
    for (int i = 0; i < 12; i++) step("after_rst");

    for (int c = 0; c < 400; c++) begin
      if (stim_q.size() == 0 && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0:       w = '0;
          1:       w = W'($urandom) & W'($urandom) & W'($urandom);
          2:       w = W'($urandom_range(0, 3)) << $urandom_range(0, W - 1);
          default: w = W'($urandom);
        endcase
        stim_q.push_back(w);
      end
      if (c == 211) do_reset("rst_rand");
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_nrzi_tx
